// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: field widths, opcode/func encodings,
// control_EX bit positions and the ID/EX payload with its bubble value.
package mips_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNC_W  = 6;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned ADDR_W  = 26;
    localparam int unsigned CTL_W   = 8;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNC_W-1:0] FN_SLL = 6'h00;
    localparam logic [FUNC_W-1:0] FN_JR  = 6'h08;
    localparam logic [FUNC_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNC_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNC_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNC_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNC_W-1:0] FN_SLT = 6'h2A;

    localparam int unsigned CTL_REG_WRITE  = 0;
    localparam int unsigned CTL_MEM_READ   = 1;
    localparam int unsigned CTL_MEM_WRITE  = 2;
    localparam int unsigned CTL_MEM_TO_REG = 3;
    localparam int unsigned CTL_BRANCH     = 4;
    localparam int unsigned CTL_JUMP       = 5;
    localparam int unsigned CTL_REG_DST    = 6;
    localparam int unsigned CTL_LINK       = 7;

    localparam logic [REG_AW-1:0] REG_RA = 5'd31;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    d1;
        logic [XLEN-1:0]    d2;
        logic [OP_W-1:0]    opcode;
        logic [FUNC_W-1:0]  func;
        logic [SHAMT_W-1:0] shamt;
        logic [IMM_W-1:0]   immediate;
        logic [ADDR_W-1:0]  address;
        logic [CTL_W-1:0]   control_ex;
        logic [REG_AW-1:0]  dest;
        logic               valid;
        logic               illegal;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/hazard_unit.sv
// Load-use / RAW hazard detection and decode-stage operand selection.
// Optional macro ID_FORWARD_EN enables EX/MEM forwarding into d1/d2.
module hazard_unit
    import mips_pkg::*;
(
    input  logic              valid_in,
    input  logic              flush_in,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              uses_rs,
    input  logic              uses_rt,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [XLEN-1:0]   rt_data,
    input  logic [REG_AW-1:0] ex_dest,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              ex_reg_write,
    input  logic              mem_reg_write,
    input  logic              ex_mem_read,
    input  logic [XLEN-1:0]   ex_result,
    input  logic [XLEN-1:0]   mem_result,
    output logic              stall,
    output logic [XLEN-1:0]   fwd_rs,
    output logic [XLEN-1:0]   fwd_rt
);

    logic ex_rs;
    logic ex_rt;
    logic mem_rs;
    logic mem_rt;
    logic load_use;
    logic raw;

    // Register 0 never matches, so it can neither stall nor forward.
    assign ex_rs  = uses_rs && (rs_addr != '0) && (rs_addr == ex_dest);
    assign ex_rt  = uses_rt && (rt_addr != '0) && (rt_addr == ex_dest);
    assign mem_rs = uses_rs && (rs_addr != '0) && (rs_addr == mem_dest);
    assign mem_rt = uses_rt && (rt_addr != '0) && (rt_addr == mem_dest);

    assign load_use = ex_mem_read && (ex_rs || ex_rt);

`ifdef ID_FORWARD_EN
    assign raw = 1'b0;

    // EX result is younger than MEM result, so it wins.
    always_comb begin
        fwd_rs = rs_data;
        fwd_rt = rt_data;
        if (ex_reg_write && !ex_mem_read && ex_rs) begin
            fwd_rs = ex_result;
        end else if (mem_reg_write && mem_rs) begin
            fwd_rs = mem_result;
        end
        if (ex_reg_write && !ex_mem_read && ex_rt) begin
            fwd_rt = ex_result;
        end else if (mem_reg_write && mem_rt) begin
            fwd_rt = mem_result;
        end
    end
`else
    logic unused_results;

    assign unused_results = ^{ex_result, mem_result};
    assign raw    = (ex_reg_write && (ex_rs || ex_rt)) ||
                    (mem_reg_write && (mem_rs || mem_rt));
    assign fwd_rs = rs_data;
    assign fwd_rt = rt_data;
`endif

    assign stall = valid_in && !flush_in && (load_use || raw);

endmodule

// File: rtl/id_ex_decode.sv
// MIPS instruction decode with ID/EX pipeline register.
// Optional macro ID_FORWARD_EN selects forwarding instead of RAW stalls.
module id_ex_decode
    import mips_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [XLEN-1:0]     instr_in,
    input  logic [XLEN-1:0]     pc_in,
    input  logic                valid_in,
    output logic [REG_AW-1:0]   rs_addr,
    output logic [REG_AW-1:0]   rt_addr,
    input  logic [XLEN-1:0]     rs_data,
    input  logic [XLEN-1:0]     rt_data,
    input  logic [REG_AW-1:0]   ex_dest,
    input  logic [REG_AW-1:0]   mem_dest,
    input  logic                ex_reg_write,
    input  logic                mem_reg_write,
    input  logic                ex_mem_read,
    input  logic [XLEN-1:0]     ex_result,
    input  logic [XLEN-1:0]     mem_result,
    input  logic                flush_in,
    output logic                stall_out,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     d1,
    output logic [XLEN-1:0]     d2,
    output logic [OP_W-1:0]     opcode,
    output logic [FUNC_W-1:0]   func,
    output logic [SHAMT_W-1:0]  shamt,
    output logic [IMM_W-1:0]    immediate,
    output logic [ADDR_W-1:0]   address,
    output logic [CTL_W-1:0]    control_EX,
    output logic [REG_AW-1:0]   dest,
    output logic                valid_out,
    output logic                illegal
);

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [CTL_W-1:0]  ctl;
    logic [REG_AW-1:0] dest_c;
    logic              legal;
    logic              uses_rs;
    logic              uses_rt;
    logic              hz_stall;
    logic [XLEN-1:0]   fwd_rs;
    logic [XLEN-1:0]   fwd_rt;
    id_ex_t            id_ex_d;
    id_ex_t            id_ex_q;

    assign op      = instr_in[31:26];
    assign rs_addr = instr_in[25:21];
    assign rt_addr = instr_in[20:16];
    assign rd      = instr_in[15:11];

    // Opcode to control_EX, plus which source registers the instruction reads.
    always_comb begin
        ctl     = '0;
        legal   = 1'b1;
        uses_rs = 1'b1;
        uses_rt = 1'b0;
        if (instr_in == '0) begin
            uses_rs = 1'b0;
        end else begin
            unique case (op)
                OP_RTYPE: begin
                    ctl[CTL_REG_WRITE] = 1'b1;
                    ctl[CTL_REG_DST]   = 1'b1;
                    uses_rt            = 1'b1;
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI: begin
                    ctl[CTL_REG_WRITE] = 1'b1;
                end
                OP_LUI: begin
                    ctl[CTL_REG_WRITE] = 1'b1;
                    uses_rs            = 1'b0;
                end
                OP_LW: begin
                    ctl[CTL_REG_WRITE]  = 1'b1;
                    ctl[CTL_MEM_READ]   = 1'b1;
                    ctl[CTL_MEM_TO_REG] = 1'b1;
                end
                OP_SW: begin
                    ctl[CTL_MEM_WRITE] = 1'b1;
                    uses_rt            = 1'b1;
                end
                OP_BEQ, OP_BNE: begin
                    ctl[CTL_BRANCH] = 1'b1;
                    uses_rt         = 1'b1;
                end
                OP_J: begin
                    ctl[CTL_JUMP] = 1'b1;
                    uses_rs       = 1'b0;
                end
                OP_JAL: begin
                    ctl[CTL_REG_WRITE] = 1'b1;
                    ctl[CTL_JUMP]      = 1'b1;
                    ctl[CTL_LINK]      = 1'b1;
                    uses_rs            = 1'b0;
                end
                default: begin
                    legal   = 1'b0;
                    uses_rs = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        dest_c = '0;
        if (ctl[CTL_REG_DST]) begin
            dest_c = rd;
        end else if (ctl[CTL_LINK]) begin
            dest_c = REG_RA;
        end else if (ctl[CTL_REG_WRITE]) begin
            dest_c = rt_addr;
        end
    end

    hazard_unit u_hazard (
        .valid_in      (valid_in),
        .flush_in      (flush_in),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .uses_rs       (uses_rs),
        .uses_rt       (uses_rt),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .ex_dest       (ex_dest),
        .mem_dest      (mem_dest),
        .ex_reg_write  (ex_reg_write),
        .mem_reg_write (mem_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_result     (ex_result),
        .mem_result    (mem_result),
        .stall         (hz_stall),
        .fwd_rs        (fwd_rs),
        .fwd_rt        (fwd_rt)
    );

    assign stall_out = reset && hz_stall;

    // Next ID/EX payload: flush, invalid and stall all collapse to a bubble.
    always_comb begin
        id_ex_d = ID_EX_BUBBLE;
        if (!reset || flush_in || !valid_in || hz_stall) begin
            id_ex_d = ID_EX_BUBBLE;
        end else if (!legal) begin
            id_ex_d.illegal = 1'b1;
        end else begin
            id_ex_d.pc         = pc_in;
            id_ex_d.d1         = fwd_rs;
            id_ex_d.d2         = fwd_rt;
            id_ex_d.opcode     = op;
            id_ex_d.func       = instr_in[5:0];
            id_ex_d.shamt      = instr_in[10:6];
            id_ex_d.immediate  = instr_in[15:0];
            id_ex_d.address    = instr_in[25:0];
            id_ex_d.control_ex = ctl;
            id_ex_d.dest       = dest_c;
            id_ex_d.valid      = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            id_ex_q <= ID_EX_BUBBLE;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign pc         = id_ex_q.pc;
    assign d1         = id_ex_q.d1;
    assign d2         = id_ex_q.d2;
    assign opcode     = id_ex_q.opcode;
    assign func       = id_ex_q.func;
    assign shamt      = id_ex_q.shamt;
    assign immediate  = id_ex_q.immediate;
    assign address    = id_ex_q.address;
    assign control_EX = id_ex_q.control_ex;
    assign dest       = id_ex_q.dest;
    assign valid_out  = id_ex_q.valid;
    assign illegal    = id_ex_q.illegal;

endmodule

// File: tb/tb_id_ex_decode.sv
// Scoreboard bench for id_ex_decode; expectations adapt to ID_FORWARD_EN.
module tb_id_ex_decode;
    import mips_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr_in, pc_in, rs_data, rt_data, ex_result, mem_result;
    logic        valid_in, ex_reg_write, mem_reg_write, ex_mem_read, flush_in;
    logic [4:0]  rs_addr, rt_addr, ex_dest, mem_dest;
    logic        stall_out;
    logic [31:0] pc, d1, d2;
    logic [5:0]  opcode, func;
    logic [4:0]  shamt, dest;
    logic [15:0] immediate;
    logic [25:0] address;
    logic [7:0]  control_EX;
    logic        valid_out, illegal;

    int     errors = 0;
    int     checks = 0;
    id_ex_t sb[$];
    id_ex_t want;
    id_ex_t got;

    always #5 clock = ~clock;

    id_ex_decode dut (
        .clock(clock), .reset(reset), .instr_in(instr_in), .pc_in(pc_in),
        .valid_in(valid_in), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .ex_dest(ex_dest),
        .mem_dest(mem_dest), .ex_reg_write(ex_reg_write),
        .mem_reg_write(mem_reg_write), .ex_mem_read(ex_mem_read),
        .ex_result(ex_result), .mem_result(mem_result), .flush_in(flush_in),
        .stall_out(stall_out), .pc(pc), .d1(d1), .d2(d2), .opcode(opcode),
        .func(func), .shamt(shamt), .immediate(immediate), .address(address),
        .control_EX(control_EX), .dest(dest), .valid_out(valid_out),
        .illegal(illegal)
    );

    function automatic id_ex_t mk(input logic [31:0] pc_v, input logic [31:0] d1_v,
                                  input logic [31:0] d2_v, input logic [31:0] ins,
                                  input logic [7:0] ctl, input logic [4:0] dst);
        id_ex_t r;
        r            = '0;
        r.pc         = pc_v;
        r.d1         = d1_v;
        r.d2         = d2_v;
        r.opcode     = ins[31:26];
        r.func       = ins[5:0];
        r.shamt      = ins[10:6];
        r.immediate  = ins[15:0];
        r.address    = ins[25:0];
        r.control_ex = ctl;
        r.dest       = dst;
        r.valid      = 1'b1;
        return r;
    endfunction

    function automatic id_ex_t sample();
        id_ex_t r;
        r.pc = pc; r.d1 = d1; r.d2 = d2; r.opcode = opcode; r.func = func;
        r.shamt = shamt; r.immediate = immediate; r.address = address;
        r.control_ex = control_EX; r.dest = dest; r.valid = valid_out;
        r.illegal = illegal;
        return r;
    endfunction

    task automatic idle();
        reset = 1'b1; instr_in = '0; pc_in = '0; valid_in = 1'b0;
        rs_data = '0; rt_data = '0; ex_dest = '0; mem_dest = '0;
        ex_reg_write = 1'b0; mem_reg_write = 1'b0; ex_mem_read = 1'b0;
        ex_result = '0; mem_result = '0; flush_in = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0; valid_in = 1'b1; instr_in = 32'h21280005; rs_data = 32'd10;
        ex_dest = 5'd9; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall_out); end
        sb.push_back(ID_EX_BUBBLE);
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL reset_out got=%h want=%h", got, want); end
    endtask

    task automatic test_addi();
        idle();
        valid_in = 1'b1; instr_in = 32'h21280005; pc_in = 32'h40;
        rs_data = 32'd10; rt_data = 32'd3;
        #1;
        checks++;
        if (stall_out !== 1'b0 || rs_addr !== 5'd9 || rt_addr !== 5'd8) begin
            errors++;
            $display("FAIL addi_addr got=%b/%0d/%0d want=0/9/8", stall_out, rs_addr, rt_addr);
        end
        sb.push_back(mk(32'h40, 32'd10, 32'd3, 32'h21280005, 8'h01, 5'd8));
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL addi_out got=%h want=%h", got, want); end
    endtask

    task automatic test_load_use();
        logic exp_stall;
        idle();
        valid_in = 1'b1; instr_in = 32'h01095020; pc_in = 32'h44;
        rs_data = 32'd99; rt_data = 32'd4;
        ex_dest = 5'd8; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        #1;
        checks++;
        if (stall_out !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b want=1", stall_out); end
        sb.push_back(ID_EX_BUBBLE);
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL lu_bubble got=%h want=%h", got, want); end
        // The load has moved on to MEM; its result is not yet in the regfile.
        ex_dest = '0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
        mem_dest = 5'd8; mem_reg_write = 1'b1; mem_result = 32'd7;
`ifdef ID_FORWARD_EN
        exp_stall = 1'b0;
        sb.push_back(mk(32'h44, 32'd7, 32'd4, 32'h01095020, 8'h41, 5'd10));
`else
        exp_stall = 1'b1;
        sb.push_back(ID_EX_BUBBLE);
`endif
        #1;
        checks++;
        if (stall_out !== exp_stall) begin errors++; $display("FAIL lu_mem_stall got=%b want=%b", stall_out, exp_stall); end
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL lu_mem_out got=%h want=%h", got, want); end
        // Write-back done: write-first regfile now returns the loaded value.
        mem_dest = '0; mem_reg_write = 1'b0; rs_data = 32'd7;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("FAIL lu_wb_stall got=%b want=0", stall_out); end
        sb.push_back(mk(32'h44, 32'd7, 32'd4, 32'h01095020, 8'h41, 5'd10));
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL lu_wb_out got=%h want=%h", got, want); end
    endtask

    task automatic test_raw_priority();
        logic exp_stall;
        idle();
        valid_in = 1'b1; instr_in = 32'h01095020; pc_in = 32'h80;
        rs_data = 32'd1; rt_data = 32'd2;
        ex_dest = 5'd8; ex_reg_write = 1'b1; ex_result = 32'd55;
        mem_dest = 5'd8; mem_reg_write = 1'b1; mem_result = 32'd66;
`ifdef ID_FORWARD_EN
        exp_stall = 1'b0;
        sb.push_back(mk(32'h80, 32'd55, 32'd2, 32'h01095020, 8'h41, 5'd10));
`else
        exp_stall = 1'b1;
        sb.push_back(ID_EX_BUBBLE);
`endif
        #1;
        checks++;
        if (stall_out !== exp_stall) begin errors++; $display("FAIL raw_ex_stall got=%b want=%b", stall_out, exp_stall); end
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL raw_ex_out got=%h want=%h", got, want); end
        ex_dest = '0; ex_reg_write = 1'b0; mem_dest = 5'd9; mem_result = 32'd77;
`ifdef ID_FORWARD_EN
        sb.push_back(mk(32'h80, 32'd1, 32'd77, 32'h01095020, 8'h41, 5'd10));
`else
        sb.push_back(ID_EX_BUBBLE);
`endif
        #1;
        checks++;
        if (stall_out !== exp_stall) begin errors++; $display("FAIL raw_rt_stall got=%b want=%b", stall_out, exp_stall); end
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL raw_rt_out got=%h want=%h", got, want); end
    endtask

    task automatic test_zero_reg();
        idle();
        valid_in = 1'b1; instr_in = 32'h00095020; pc_in = 32'h90;
        rs_data = 32'd0; rt_data = 32'd5;
        ex_dest = '0; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_result = 32'hDEAD;
        mem_dest = '0; mem_reg_write = 1'b1; mem_result = 32'hBEEF;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("FAIL zero_stall got=%b want=0", stall_out); end
        sb.push_back(mk(32'h90, 32'd0, 32'd5, 32'h00095020, 8'h41, 5'd10));
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL zero_out got=%h want=%h", got, want); end
    endtask

    task automatic test_flush();
        idle();
        valid_in = 1'b1; instr_in = 32'h01095020; flush_in = 1'b1;
        ex_dest = 5'd8; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b want=0", stall_out); end
        sb.push_back(ID_EX_BUBBLE);
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL flush_out got=%h want=%h", got, want); end
        idle();
        valid_in = 1'b1; instr_in = 32'hFC000000; flush_in = 1'b1;
        sb.push_back(ID_EX_BUBBLE);
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL flush_illegal got=%h want=%h", got, want); end
    endtask

    task automatic test_illegal();
        id_ex_t ill;
        idle();
        ill = ID_EX_BUBBLE;
        ill.illegal = 1'b1;
        valid_in = 1'b1; instr_in = 32'hFC000000; pc_in = 32'hA0;
        sb.push_back(ill);
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL illegal_pulse got=%h want=%h", got, want); end
        valid_in = 1'b0;
        sb.push_back(ID_EX_BUBBLE);
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL illegal_drop got=%h want=%h", got, want); end
    endtask

    task automatic test_jal();
        idle();
        valid_in = 1'b1; instr_in = 32'h0C000010; pc_in = 32'h100;
        sb.push_back(mk(32'h100, 32'd0, 32'd0, 32'h0C000010, 8'hA1, 5'd31));
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL jal_out got=%h want=%h", got, want); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [12] = '{32'h8D280004, 32'hAD280004, 32'h11090003, 32'h15090003,
                                 32'h08000040, 32'h00000000, 32'h35280005, 32'h3C080001,
                                 32'h29280005, 32'h25280005, 32'h31280005, 32'h21280005};
        logic [7:0]  ctl [12] = '{8'h0B, 8'h04, 8'h10, 8'h10, 8'h20, 8'h00,
                                 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
        logic [4:0]  dst [12] = '{5'd8, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0,
                                 5'd8, 5'd8, 5'd8, 5'd8, 5'd8, 5'd0};
        idle();
        for (int i = 0; i < 12; i++) begin
            instr_in = ins[i];
            pc_in    = 32'h200 + 32'(i * 4);
            rs_data  = 32'h1000 + 32'(i);
            rt_data  = 32'h2000 + 32'(i);
            valid_in = (i != 11);
            if (i == 11) sb.push_back(ID_EX_BUBBLE);
            else sb.push_back(mk(pc_in, rs_data, rt_data, ins[i], ctl[i], dst[i]));
            tick();
            want = sb.pop_front(); got = sample(); checks++;
            if (got !== want) begin errors++; $display("FAIL b2b_%0d got=%h want=%h", i, got, want); end
        end
    endtask

    task automatic test_reset_mid_stall();
        idle();
        valid_in = 1'b1; instr_in = 32'h01095020; pc_in = 32'h300;
        rs_data = 32'd3; rt_data = 32'd4;
        ex_dest = 5'd9; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        #1;
        checks++;
        if (stall_out !== 1'b1) begin errors++; $display("FAIL rms_stall got=%b want=1", stall_out); end
        reset = 1'b0;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("FAIL rms_reset_stall got=%b want=0", stall_out); end
        sb.push_back(ID_EX_BUBBLE);
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL rms_out got=%h want=%h", got, want); end
        reset = 1'b1; ex_dest = '0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin errors++; $display("FAIL rms_release got=%b want=0", stall_out); end
        sb.push_back(mk(32'h300, 32'd3, 32'd4, 32'h01095020, 8'h41, 5'd10));
        tick();
        want = sb.pop_front(); got = sample(); checks++;
        if (got !== want) begin errors++; $display("FAIL rms_resume got=%h want=%h", got, want); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_raw_priority();
        test_zero_reg();
        test_flush();
        test_illegal();
        test_jal();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_decode.md
ID_EX_DECODE -- requirements
Module: id_ex_decode

Interface
REQ-001 SHALL expose: clock  in  1  rising-edge clock.
REQ-002 SHALL expose: reset  in  1  reset, synchronous, active-low.
REQ-003 SHALL expose: instr_in  in  32  instruction from IF/ID; pc_in  in  32  its PC; valid_in  in  1  instr_in valid.
REQ-004 SHALL expose: rs_addr, rt_addr  out  5 each  combinational regfile read addresses; rs_data, rt_data  in  32 each  regfile read data, write-first.
REQ-005 SHALL expose: ex_dest, mem_dest  in  5 each; ex_reg_write, mem_reg_write, ex_mem_read  in  1 each; ex_result, mem_result  in  32 each  downstream hazard/forward info.
REQ-006 SHALL expose: flush_in  in  1  squash the decode slot (taken branch/jump).
REQ-007 SHALL expose: stall_out  out  1  combinational hold request to IF/ID.
REQ-008 SHALL expose registered ALU-facing outputs: pc 32, d1 32, d2 32, opcode 6, func 6, shamt 5, immediate 16, address 26, control_EX 8, dest 5, valid_out 1, illegal 1.

Function
REQ-009 SHALL register all REQ-008 outputs once per clock; latency one cycle from instr_in to outputs.
REQ-010 SHALL slice fields: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], func=[5:0], immediate=[15:0], address=[25:0]; rs_addr=rs, rt_addr=rt.
REQ-011 SHALL encode control_EX bits: 0 reg_write, 1 mem_read, 2 mem_write, 3 mem_to_reg, 4 branch, 5 jump, 6 reg_dst, 7 link.
REQ-012 SHALL decode: R-type 000000 -> 0x41; addi/addiu/slti/andi/ori/lui -> 0x01; lw -> 0x0B; sw -> 0x04; beq/bne -> 0x10; j -> 0x20; jal -> 0xA1; instr_in==0 (NOP) -> 0x00.
REQ-013 SHALL set dest: rd when reg_dst, 31 when link, rt for other reg_write, 0 otherwise.
REQ-014 SHALL treat unlisted opcodes as illegal: issue a bubble and pulse illegal high for exactly one cycle.
REQ-015 A bubble SHALL be: control_EX=0, valid_out=0, dest=0, illegal=0 unless REQ-014; data fields don't-care but driven 0.
REQ-016 SHALL raise stall_out on load-use: valid_in, ex_mem_read, ex_dest!=0, ex_dest equals rs (or rt when instruction reads rt).
REQ-017 While stall_out=1 SHALL issue a bubble; upstream holds instr_in so it re-presents next cycle.
REQ-018 flush_in SHALL have priority over stall: output bubble, stall_out=0, illegal suppressed.
REQ-019 valid_in=0 SHALL issue a bubble, stall_out=0.
REQ-020 Hazard compare against register 0 SHALL never stall or forward.

Reset
REQ-021 With reset=0 at a clock edge, all REQ-008 outputs SHALL be 0 next cycle; stall_out SHALL be 0 while reset=0.
REQ-022 Reset mid-stall SHALL discard the held instruction state; no residual stall after release.

Configuration
REQ-023 SHALL support macro ID_FORWARD_EN.
REQ-024 With ID_FORWARD_EN: d1/d2 take ex_result if ex_reg_write&&!ex_mem_read&&ex_dest match, else mem_result if mem_reg_write&&mem_dest match, else regfile; EX has priority over MEM.
REQ-025 Without ID_FORWARD_EN: d1/d2 from regfile only; stall_out additionally asserts on any RAW match against ex_dest (ex_reg_write) or mem_dest (mem_reg_write).

Structure
REQ-026 Shared package mips_pkg SHALL hold opcode/func constants, control_EX bit indices, and the bubble constant.
REQ-027 Hazard/forward logic SHALL be one sub-module, hazard_unit; decode and pipeline register stay in id_ex_decode.

Verification
REQ-028 reset=0 one cycle with instr_in=0x21280005 -> all outputs 0, stall_out=0.
REQ-029 addi 0x21280005, rs_data=10, no hazards -> next cycle opcode=001000, d1=10, immediate=5, dest=8, control_EX=0x01, valid_out=1.
REQ-030 ex lw ex_dest=8, ex_mem_read=1; add 0x01095020 -> stall_out=1, bubble; next cycle with mem_dest=8, mem_result=7 (FORWARD_EN) -> d1=7, dest=10, control_EX=0x41.
REQ-031 flush_in=1 and load-use stall simultaneously -> bubble, stall_out=0.
REQ-032 instr_in=0xFC000000 -> illegal=1 one cycle, control_EX=0, valid_out=0.
REQ-033 jal 0x0C000010, pc_in=0x100 -> address=0x10, dest=31, control_EX=0xA1, pc=0x100.
